// File: rtl/cc1200_spi_pkg.sv
// Shared constants, FSM encoding and status-byte helper for the CC1200 SPI responder.
package cc1200_spi_pkg;

   localparam int ADDR_W          = 6;
   localparam int DATA_W          = 8;
   localparam int RW_BIT          = 7;
   localparam int BURST_BIT       = 6;
   localparam int STATUS_RDYN_BIT = 7;

   localparam logic [ADDR_W-1:0] ADDR_SRES  = 6'h30;
   localparam logic [ADDR_W-1:0] ADDR_SRX   = 6'h34;
   localparam logic [ADDR_W-1:0] ADDR_STX   = 6'h35;
   localparam logic [ADDR_W-1:0] ADDR_SIDLE = 6'h36;
   localparam logic [ADDR_W-1:0] STROBE_LO  = 6'h30;
   localparam logic [ADDR_W-1:0] STROBE_HI  = 6'h3D;

   typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_DATA, ST_IGNORE} state_e;

   // Bit alignment after a chip select that arrived while SCLK was high.
   typedef enum logic [1:0] {ALIGN_OK, WAIT_RISE, WAIT_FALL} align_e;

   function automatic logic [DATA_W-1:0] status_byte(input logic [2:0] st);
      logic [DATA_W-1:0] s;
      s                  = '0;
      s[6:4]             = st;
      s[STATUS_RDYN_BIT] = 1'b0;
      return s;
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Synchronizes SCLK/MOSI/CS_n into clk and produces single-cycle edge pulses.
module spi_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic sclk_i,
   input  logic mosi_i,
   input  logic cs_n_i,
   output logic sclk_o,
   output logic sclk_rise_o,
   output logic sclk_fall_o,
   output logic cs_fall_o,
   output logic cs_rise_o,
   output logic mosi_o
);

   logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, cs_sync_q;
   logic                   sclk_prev_q, cs_prev_q;

   // The cs_n chain resets low so a select already active during reset is never
   // mistaken for a fresh fall; the master must deselect and reselect first.
   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_sync_q <= '0;
         mosi_sync_q <= '0;
         cs_sync_q   <= '0;
         sclk_prev_q <= 1'b0;
         cs_prev_q   <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_i};
         sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
         cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
      end
   end

   assign sclk_o      = sclk_sync_q[SYNC_STAGES-1];
   assign mosi_o      = mosi_sync_q[SYNC_STAGES-1];
   assign sclk_rise_o = sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
   assign sclk_fall_o = ~sclk_sync_q[SYNC_STAGES-1] & sclk_prev_q;
   assign cs_fall_o   = ~cs_sync_q[SYNC_STAGES-1] & cs_prev_q;
   assign cs_rise_o   = cs_sync_q[SYNC_STAGES-1] & ~cs_prev_q;

endmodule

// File: rtl/cc1200_spi_responder.sv
// CC1200 register-interface SPI slave with a 64x8 register file.
// Optional command strobes: define CC1200_SPI_RESP_STROBE_EN.
module cc1200_spi_responder
   import cc1200_spi_pkg::*;
#(
   parameter int                SYNC_STAGES = 2,
   parameter logic [DATA_W-1:0] REG_RESET   = 8'h00
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sclk,
   input  logic              mosi,
   input  logic              cs_n,
   output logic              miso,
   output logic              miso_oe,
   input  logic [2:0]        chip_state,
   input  logic [ADDR_W-1:0] loc_addr,
   output logic [DATA_W-1:0] loc_rdata,
   output logic              wr_valid,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              busy
`ifdef CC1200_SPI_RESP_STROBE_EN
   ,
   output logic              cmd_valid,
   output logic [ADDR_W-1:0] cmd_addr
`endif
);

   logic sclk_s, sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_s;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk         (clk),
      .rst         (rst),
      .sclk_i      (sclk),
      .mosi_i      (mosi),
      .cs_n_i      (cs_n),
      .sclk_o      (sclk_s),
      .sclk_rise_o (sclk_rise),
      .sclk_fall_o (sclk_fall),
      .cs_fall_o   (cs_fall),
      .cs_rise_o   (cs_rise),
      .mosi_o      (mosi_s)
   );

   state_e            state_q;
   align_e            align_q;
   logic [2:0]        bit_cnt_q;
   logic [DATA_W-1:0] rx_q, tx_q;
   logic              rw_q, burst_q;
   logic [ADDR_W-1:0] addr_q;
   logic              miso_q, miso_oe_q, busy_q, wr_valid_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [DATA_W-1:0] wr_data_q, loc_rdata_q;
   logic [DATA_W-1:0] regs_q [2**ADDR_W];
   logic [2:0]        status_st;

   logic [DATA_W-1:0] rx_byte_d;
   logic [ADDR_W-1:0] hdr_addr_d, addr_inc_d;
   logic              byte_done_d, hdr_done_d, data_done_d, reg_we_d, strobe_d, reg_clr_d;

`ifdef CC1200_SPI_RESP_STROBE_EN
   logic              cmd_valid_q;
   logic [ADDR_W-1:0] cmd_addr_q;
   logic [2:0]        strobe_st_q;
   logic              unused_chip_state;

   assign unused_chip_state = ^chip_state;
   assign status_st         = strobe_st_q;
   assign cmd_valid         = cmd_valid_q;
   assign cmd_addr          = cmd_addr_q;
`else
   assign status_st = chip_state;
`endif

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      strobe_d    = 1'b0;
      reg_clr_d   = 1'b0;
      rx_byte_d   = {rx_q[DATA_W-2:0], mosi_s};
      hdr_addr_d  = rx_byte_d[ADDR_W-1:0];
      addr_inc_d  = addr_q + ADDR_W'(1);
      byte_done_d = sclk_rise && !cs_rise && (align_q == ALIGN_OK) && (bit_cnt_q == 3'd7)
                    && (state_q == ST_HDR || state_q == ST_DATA);
      hdr_done_d  = byte_done_d && (state_q == ST_HDR);
      data_done_d = byte_done_d && (state_q == ST_DATA);
      reg_we_d    = data_done_d && !rw_q;
`ifdef CC1200_SPI_RESP_STROBE_EN
      strobe_d    = hdr_done_d && !rx_byte_d[RW_BIT] && !rx_byte_d[BURST_BIT]
                    && (hdr_addr_d >= STROBE_LO) && (hdr_addr_d <= STROBE_HI);
      reg_clr_d   = strobe_d && (hdr_addr_d == ADDR_SRES);
`endif
   end

   // NOTE: sequential state uses non-blocking assignments only; later assignments
   // in this block deliberately override earlier ones (byte completion wins over shifting).
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         align_q    <= ALIGN_OK;
         bit_cnt_q  <= '0;
         rx_q       <= '0;
         tx_q       <= '0;
         rw_q       <= 1'b0;
         burst_q    <= 1'b0;
         addr_q     <= '0;
         miso_q     <= 1'b0;
         miso_oe_q  <= 1'b0;
         busy_q     <= 1'b0;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
`ifdef CC1200_SPI_RESP_STROBE_EN
         cmd_valid_q <= 1'b0;
         cmd_addr_q  <= '0;
         strobe_st_q <= 3'b000;
`endif
      end else begin
         wr_valid_q <= 1'b0;
`ifdef CC1200_SPI_RESP_STROBE_EN
         cmd_valid_q <= 1'b0;
`endif
         if (cs_rise) begin
            state_q   <= ST_IDLE;
            miso_q    <= 1'b0;
            miso_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            tx_q      <= '0;
         end else if (state_q == ST_IDLE) begin
            if (cs_fall) begin
               state_q        <= ST_HDR;
               busy_q         <= 1'b1;
               miso_oe_q      <= 1'b1;
               {miso_q, tx_q} <= {status_byte(status_st), 1'b0};
               bit_cnt_q      <= '0;
               align_q        <= sclk_s ? WAIT_RISE : ALIGN_OK;
            end
         end else begin
            if (sclk_rise) begin
               if (align_q == WAIT_RISE) begin
                  align_q <= WAIT_FALL;
               end else if (align_q == ALIGN_OK) begin
                  rx_q      <= rx_byte_d;
                  bit_cnt_q <= bit_cnt_q + 3'd1;
               end
            end
            if (sclk_fall) begin
               if (align_q == WAIT_FALL) begin
                  align_q <= ALIGN_OK;
               end else if (align_q == ALIGN_OK) begin
                  miso_q <= (state_q != ST_IGNORE) && tx_q[DATA_W-1];
                  tx_q   <= tx_q << 1;
               end
            end
            if (hdr_done_d) begin
               rw_q    <= rx_byte_d[RW_BIT];
               burst_q <= rx_byte_d[BURST_BIT];
               addr_q  <= hdr_addr_d;
               if (strobe_d) begin
                  state_q <= ST_IGNORE;
                  tx_q    <= '0;
`ifdef CC1200_SPI_RESP_STROBE_EN
                  cmd_valid_q <= 1'b1;
                  cmd_addr_q  <= hdr_addr_d;
                  case (hdr_addr_d)
                     ADDR_SIDLE: strobe_st_q <= 3'b000;
                     ADDR_SRX:   strobe_st_q <= 3'b001;
                     ADDR_STX:   strobe_st_q <= 3'b010;
                     ADDR_SRES:  strobe_st_q <= 3'b000;
                     default:    ;
                  endcase
`endif
               end else begin
                  state_q <= ST_DATA;
                  tx_q    <= rx_byte_d[RW_BIT] ? regs_q[hdr_addr_d] : '0;
               end
            end
            if (data_done_d) begin
               if (!rw_q) begin
                  wr_valid_q <= 1'b1;
                  wr_addr_q  <= addr_q;
                  wr_data_q  <= rx_byte_d;
               end
               if (burst_q) begin
                  addr_q <= addr_inc_d;
                  tx_q   <= rw_q ? regs_q[addr_inc_d] : '0;
               end else begin
                  state_q <= ST_IGNORE;
                  tx_q    <= '0;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) loc_rdata_q <= '0;
      else     loc_rdata_q <= regs_q[loc_addr];
      // NOTE: the register file is built from flops, so it can be reset like any other state.
      if (rst || reg_clr_d) begin
         for (int i = 0; i < 2**ADDR_W; i++) regs_q[i] <= REG_RESET;
      end else if (reg_we_d) begin
         regs_q[addr_q] <= rx_byte_d;
      end
   end

   assign miso      = miso_q;
   assign miso_oe   = miso_oe_q;
   assign busy      = busy_q;
   assign wr_valid  = wr_valid_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign loc_rdata = loc_rdata_q;

endmodule

// File: tb/tb_cc1200_spi_responder.sv
// Self-checking bench for cc1200_spi_responder: a transaction-level register model
// plus a per-cycle compare process for write pulses and idle-time outputs.
module tb_cc1200_spi_responder;

   localparam int SYNC_STAGES = 2;
   localparam int HALF        = 6;

   logic       clk = 1'b0, rst = 1'b1, sclk = 1'b0, mosi = 1'b0, cs_n = 1'b1;
   logic       miso, miso_oe, wr_valid, busy;
   logic [2:0] chip_state = 3'b000;
   logic [5:0] loc_addr = 6'h00, wr_addr;
   logic [7:0] loc_rdata, wr_data;
`ifdef CC1200_SPI_RESP_STROBE_EN
   logic       cmd_valid;
   logic [5:0] cmd_addr;
   logic [5:0] exp_cmd_q [$];
   logic [2:0] model_st = 3'b000;
`endif

   int          n_cmp = 0, n_err = 0;
   logic [7:0]  model_regs [64];
   logic [13:0] exp_wr_q [$];
   logic [13:0] wr_e;
   logic        settled = 1'b0;
   logic [7:0]  txd [$];
   logic [7:0]  rxd [$];
   logic [7:0]  rb;

   always #5 clk = ~clk;

   cc1200_spi_responder #(.SYNC_STAGES(SYNC_STAGES), .REG_RESET(8'h00)) dut (
      .clk        (clk),
      .rst        (rst),
      .sclk       (sclk),
      .mosi       (mosi),
      .cs_n       (cs_n),
      .miso       (miso),
      .miso_oe    (miso_oe),
      .chip_state (chip_state),
      .loc_addr   (loc_addr),
      .loc_rdata  (loc_rdata),
      .wr_valid   (wr_valid),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .busy       (busy)
`ifdef CC1200_SPI_RESP_STROBE_EN
      ,
      .cmd_valid  (cmd_valid),
      .cmd_addr   (cmd_addr)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Write pulses are matched against the model's queue; idle outputs are checked every cycle.
   always @(negedge clk) begin
      if (wr_valid) begin
         check("wr_valid_expected", 32'(wr_valid), 32'(exp_wr_q.size() != 0));
         if (exp_wr_q.size() != 0) begin
            wr_e = exp_wr_q.pop_front();
            check("wr_addr", 32'(wr_addr), 32'(wr_e[13:8]));
            check("wr_data", 32'(wr_data), 32'(wr_e[7:0]));
         end
      end
`ifdef CC1200_SPI_RESP_STROBE_EN
      if (cmd_valid) begin
         check("cmd_valid_expected", 32'(cmd_valid), 32'(exp_cmd_q.size() != 0));
         if (exp_cmd_q.size() != 0) check("cmd_addr", 32'(cmd_addr), 32'(exp_cmd_q.pop_front()));
      end
`endif
      if (settled) begin
         check("idle_loc_rdata", 32'(loc_rdata), 32'(model_regs[loc_addr]));
         check("idle_busy", 32'(busy), 32'(0));
         check("idle_miso_oe", 32'(miso_oe), 32'(0));
      end
   end

   function automatic logic [7:0] exp_status();
`ifdef CC1200_SPI_RESP_STROBE_EN
      return {1'b0, model_st, 4'b0000};
`else
      return {1'b0, chip_state, 4'b0000};
`endif
   endfunction

   task automatic half();
      repeat (HALF) @(negedge clk);
   endtask

   task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 7; i > 7 - nbits; i--) begin
         mosi  = tx[i];
         half();
         sclk  = 1'b1;
         rx[i] = miso;
         half();
         sclk  = 1'b0;
      end
   endtask

   task automatic set_loc(input logic [5:0] a);
      settled  = 1'b0;
      loc_addr = a;
      repeat (2) @(negedge clk);
      settled  = 1'b1;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_miso"}, 32'(miso), 32'(0));
      check({tag, "_miso_oe"}, 32'(miso_oe), 32'(0));
      check({tag, "_busy"}, 32'(busy), 32'(0));
      check({tag, "_wr_valid"}, 32'(wr_valid), 32'(0));
      check({tag, "_wr_addr"}, 32'(wr_addr), 32'(0));
      check({tag, "_wr_data"}, 32'(wr_data), 32'(0));
      check({tag, "_loc_rdata"}, 32'(loc_rdata), 32'(0));
   endtask

   // One full transaction: header then txd[]; expectations come from the register model.
   task automatic txn(input logic [7:0] hdr);
      logic       rw, bu, active;
      logic [5:0] a;
      logic [7:0] r;
      rw = hdr[7];
      bu = hdr[6];
      a  = hdr[5:0];
      active = 1'b1;
      rxd.delete();
      settled = 1'b0;
      cs_n    = 1'b0;
      half();
      spi_bits(hdr, 8, r);
      check("status_byte", 32'(r), 32'(exp_status()));
      rxd.push_back(r);
`ifdef CC1200_SPI_RESP_STROBE_EN
      if (!rw && !bu && a >= 6'h30 && a <= 6'h3D) begin
         exp_cmd_q.push_back(a);
         case (a)
            6'h36: model_st = 3'b000;
            6'h34: model_st = 3'b001;
            6'h35: model_st = 3'b010;
            6'h30: begin
               model_st = 3'b000;
               foreach (model_regs[i]) model_regs[i] = 8'h00;
            end
            default: ;
         endcase
         active = 1'b0;
      end
`endif
      foreach (txd[k]) begin
         if (!rw && active) begin
            model_regs[a] = txd[k];
            exp_wr_q.push_back({a, txd[k]});
         end
         spi_bits(txd[k], 8, r);
         rxd.push_back(r);
         if (rw) check("read_byte", 32'(r), 32'(active ? model_regs[a] : 8'h00));
         if (active && bu) a = a + 6'd1;
         else active = 1'b0;
      end
      half();
      cs_n = 1'b1;
      repeat (HALF) @(negedge clk);
      settled = 1'b1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      foreach (model_regs[i]) model_regs[i] = 8'h00;
      repeat (4) @(negedge clk);
      check_reset("reset");
      rst = 1'b0;
      repeat (4) @(negedge clk);
      settled = 1'b1;

      // Single write, then local readback.
      txd = {8'hA5};
      txn(8'h03);
      set_loc(6'h03);
      check("write_loc_rdata", 32'(loc_rdata), 32'h0000_00A5);

      // Single read with chip_state reported, plus a trailing ignored byte.
      chip_state = 3'b001;
      txd = {8'h00, 8'h00};
      txn(8'h83);
`ifndef CC1200_SPI_RESP_STROBE_EN
      check("read_status_lit", 32'(rxd[0]), 32'h0000_0010);
`endif
      check("read_data_lit", 32'(rxd[1]), 32'h0000_00A5);
      check("read_ignore_lit", 32'(rxd[2]), 32'h0000_0000);

      // Burst write across the 6'h3F -> 6'h00 wrap, then burst read back.
      txd = {8'h11, 8'h22, 8'h33};
      txn(8'h7E);
      txd = {8'h00, 8'h00, 8'h00};
      txn(8'hFE);
      check("burst_rd0_lit", 32'(rxd[1]), 32'h0000_0011);
      check("burst_rd1_lit", 32'(rxd[2]), 32'h0000_0022);
      check("burst_rd2_lit", 32'(rxd[3]), 32'h0000_0033);
      set_loc(6'h00);
      check("wrap_loc_lit", 32'(loc_rdata), 32'h0000_0033);

      // Abort mid-byte: no write, output enable drops within SYNC_STAGES+1 clocks.
      settled = 1'b0;
      cs_n    = 1'b0;
      half();
      spi_bits(8'h05, 8, rb);
      spi_bits(8'hFF, 5, rb);
      check("abort_oe_before", 32'(miso_oe), 32'(1));
      cs_n = 1'b1;
      repeat (SYNC_STAGES + 1) @(posedge clk);
      #1;
      check("abort_miso_oe", 32'(miso_oe), 32'(0));
      check("abort_busy", 32'(busy), 32'(0));
      check("abort_miso", 32'(miso), 32'(0));
      repeat (HALF) @(negedge clk);
      settled = 1'b1;
      set_loc(6'h05);
      check("abort_reg5_lit", 32'(loc_rdata), 32'h0000_0000);

      // Reset during data bit 3; the rest of that transaction must be ignored.
      set_loc(6'h03);
      settled = 1'b0;
      cs_n    = 1'b0;
      half();
      spi_bits(8'h01, 8, rb);
      spi_bits(8'h5A, 3, rb);
      mosi = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_reset("rstmid");
      rst = 1'b0;
      foreach (model_regs[i]) model_regs[i] = 8'h00;
      repeat (HALF - 3) @(negedge clk);
      sclk = 1'b1;
      half();
      sclk = 1'b0;
      spi_bits(8'hFF, 4, rb);
      check("rstmid_busy_after", 32'(busy), 32'(0));
      check("rstmid_oe_after", 32'(miso_oe), 32'(0));
      half();
      cs_n = 1'b1;
      repeat (HALF) @(negedge clk);
      settled = 1'b1;
      txd = {8'h5A};
      txn(8'h01);
      set_loc(6'h01);
      check("rstmid_write_lit", 32'(loc_rdata), 32'h0000_005A);

`ifdef CC1200_SPI_RESP_STROBE_EN
      txd.delete();
      txn(8'h34);
      txd = {8'h00};
      txn(8'h83);
      check("strobe_status_lit", 32'(rxd[0]), 32'h0000_0010);
      txd.delete();
      txn(8'h30);
      set_loc(6'h01);
      check("sres_clear_lit", 32'(loc_rdata), 32'h0000_0000);
      check("cmd_missing", 32'(exp_cmd_q.size()), 32'(0));
`endif

      repeat (4) @(negedge clk);
      check("wr_missing", 32'(exp_wr_q.size()), 32'(0));
      settled = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
